// File: rtl/instr_pkg.sv
// Shared types and helpers for the instruction fetch queue: MIPS field layout,
// decoded-field struct and 16-bit immediate sign extension.
package instr_pkg;

   localparam int unsigned OpcodeW  = 6;
   localparam int unsigned RegW     = 5;
   localparam int unsigned FunctW   = 6;
   localparam int unsigned ImmW     = 16;
   localparam int unsigned TargetW  = 26;

   localparam int unsigned OpcodeLsb = 26;
   localparam int unsigned RsLsb     = 21;
   localparam int unsigned RtLsb     = 16;
   localparam int unsigned RdLsb     = 11;
   localparam int unsigned ShamtLsb  = 6;
   localparam int unsigned FunctLsb  = 0;
   localparam int unsigned ImmLsb    = 0;
   localparam int unsigned TargetLsb = 0;

   typedef struct packed {
      logic [OpcodeW-1:0] opcode;
      logic [RegW-1:0]    rs;
      logic [RegW-1:0]    rt;
      logic [RegW-1:0]    rd;
      logic [RegW-1:0]    shamt;
      logic [FunctW-1:0]  funct;
      logic [ImmW-1:0]    imm16;
      logic [TargetW-1:0] target26;
   } instr_fields_t;

   // Wide enough for any extended-immediate width up to 64 bits; callers truncate.
   function automatic logic [63:0] sign_ext16(input logic [15:0] v);
      return {{48{v[15]}}, v};
   endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch/decode handshake bundle of the instruction fetch queue. The queue uses
// the slave modport; the fetch/decode environment drives the master side.
interface instr_fetch_queue_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IMM_W = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr_in;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      instr_out;
   logic [5:0]       opcode;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic [4:0]       shamt;
   logic [5:0]       funct;
   logic [15:0]      imm16;
   logic [IMM_W-1:0] imm_ext;
   logic [25:0]      target26;
   logic [CNT_W-1:0] count;

   modport master (
      output flush, in_valid, instr_in, out_ready,
      input  in_ready, out_valid, instr_out, opcode, rs, rt, rd, shamt, funct,
             imm16, imm_ext, target26, count
   );

   modport slave (
      input  flush, in_valid, instr_in, out_ready,
      output in_ready, out_valid, instr_out, opcode, rs, rt, rd, shamt, funct,
             imm16, imm_ext, target26, count
   );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational MIPS field slicer; every output is forced to zero when the
// word is not valid so decode never sees stale storage contents.
module instr_field_decode
   import instr_pkg::*;
(
   input  logic [31:0]   word_i,
   input  logic          valid_i,
   output logic [31:0]   word_o,
   output instr_fields_t fields_o
);

   always_comb begin
      word_o   = '0;
      fields_o = '0;
      if (valid_i) begin
         word_o            = word_i;
         fields_o.opcode   = word_i[OpcodeLsb +: OpcodeW];
         fields_o.rs       = word_i[RsLsb +: RegW];
         fields_o.rt       = word_i[RtLsb +: RegW];
         fields_o.rd       = word_i[RdLsb +: RegW];
         fields_o.shamt    = word_i[ShamtLsb +: RegW];
         fields_o.funct    = word_i[FunctLsb +: FunctW];
         fields_o.imm16    = word_i[ImmLsb +: ImmW];
         fields_o.target26 = word_i[TargetLsb +: TargetW];
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode with flush and decoded head fields.
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module instr_fetch_queue
   import instr_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IMM_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   instr_fetch_queue_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned PtrW  = $clog2(DEPTH);

   logic [31:0]      mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic          full, empty, bypass;
   logic          push, pop, wr_en, rd_en;
   logic [31:0]   head_word;
   logic [31:0]   word_masked;
   instr_fields_t fields;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = empty & bus.in_valid & ~bus.flush;
`else
   assign bypass = 1'b0;
`endif

   assign bus.in_ready  = ~full & ~bus.flush;
   assign bus.out_valid = ~empty | bypass;

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   // A bypassed word consumed in its arrival cycle never touches storage.
   assign wr_en = push & ~(bypass & bus.out_ready);
   assign rd_en = pop & ~bypass;

   assign head_word = bypass ? bus.instr_in : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (reset || bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem_q[wr_ptr_q] <= bus.instr_in;
   end

   instr_field_decode u_decode (
      .word_i   (head_word),
      .valid_i  (bus.out_valid),
      .word_o   (word_masked),
      .fields_o (fields)
   );

   assign bus.instr_out = word_masked;
   assign bus.opcode    = fields.opcode;
   assign bus.rs        = fields.rs;
   assign bus.rt        = fields.rt;
   assign bus.rd        = fields.rd;
   assign bus.shamt     = fields.shamt;
   assign bus.funct     = fields.funct;
   assign bus.imm16     = fields.imm16;
   assign bus.imm_ext   = IMM_W'(sign_ext16(fields.imm16));
   assign bus.target26  = fields.target26;
   assign bus.count     = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=4, IMM_W=32).
module tb_instr_fetch_queue;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch_queue_if #(.DEPTH(4), .IMM_W(32)) bus ();

   instr_fetch_queue #(.DEPTH(4), .IMM_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      bus.in_valid = 1'b1;
      bus.instr_in = w;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic pop_one();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   // Fill past capacity with words base+i, then drain and check order.
   task automatic fill_drain(input logic [31:0] base);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.instr_in = base + 32'(i);
         #1;
         check_eq("fill_in_ready", 64'(bus.in_ready), (i < 4) ? 64'd1 : 64'd0);
         tick();
      end
      bus.in_valid = 1'b0;
      #1;
      check_eq("fill_count", 64'(bus.count), 64'd4);
      check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq("drain_word", 64'(bus.instr_out), 64'(base + 32'(i)));
         check_eq("drain_count", 64'(bus.count), 64'(4 - i));
         tick();
      end
      bus.out_ready = 1'b0;
      #1;
      check_eq("drained_count", 64'(bus.count), 64'd0);
      check_eq("drained_valid", 64'(bus.out_valid), 64'd0);
   endtask

   logic [31:0] seq [8];

   initial begin
      reset         = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.instr_in  = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Reset state
      check_eq("rst_count", 64'(bus.count), 64'd0);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("rst_instr_out", 64'(bus.instr_out), 64'd0);
      check_eq("rst_opcode", 64'(bus.opcode), 64'd0);
      check_eq("rst_imm_ext", 64'(bus.imm_ext), 64'd0);
      check_eq("rst_target", 64'(bus.target26), 64'd0);

      // add $8,$9,$10
      push_word(32'h012A_4020);
      check_eq("add_valid", 64'(bus.out_valid), 64'd1);
      check_eq("add_opcode", 64'(bus.opcode), 64'd0);
      check_eq("add_rs", 64'(bus.rs), 64'd9);
      check_eq("add_rt", 64'(bus.rt), 64'd10);
      check_eq("add_rd", 64'(bus.rd), 64'd8);
      check_eq("add_shamt", 64'(bus.shamt), 64'd0);
      check_eq("add_funct", 64'(bus.funct), 64'h20);
      check_eq("add_count", 64'(bus.count), 64'd1);
      pop_one();
      check_eq("add_popped", 64'(bus.count), 64'd0);

      // addi $8,$9,-4
      push_word(32'h2128_FFFC);
      check_eq("addi_opcode", 64'(bus.opcode), 64'h08);
      check_eq("addi_rs", 64'(bus.rs), 64'd9);
      check_eq("addi_rt", 64'(bus.rt), 64'd8);
      check_eq("addi_imm16", 64'(bus.imm16), 64'hFFFC);
      check_eq("addi_imm_ext", 64'(bus.imm_ext), 64'hFFFF_FFFC);
      check_eq("addi_target", 64'(bus.target26), 64'h128_FFFC);
      pop_one();

      // Pointers now sit at 2, so both fills wrap.
      fill_drain(32'h8C00_0000);
      fill_drain(32'hAC10_0010);

      // Steady push+pop at count 2
      for (int i = 0; i < 8; i++) seq[i] = 32'h3C00_0100 + 32'(i);
      push_word(seq[0]);
      push_word(seq[1]);
      for (int k = 0; k < 6; k++) begin
         bus.in_valid  = 1'b1;
         bus.instr_in  = seq[k + 2];
         bus.out_ready = 1'b1;
         #1;
         check_eq("stream_head", 64'(bus.instr_out), 64'(seq[k]));
         check_eq("stream_count", 64'(bus.count), 64'd2);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check_eq("stream_end_head", 64'(bus.instr_out), 64'(seq[6]));
      check_eq("stream_end_count", 64'(bus.count), 64'd2);
      pop_one();
      check_eq("stream_last_head", 64'(bus.instr_out), 64'(seq[7]));
      pop_one();
      check_eq("stream_empty", 64'(bus.count), 64'd0);

      // Flush at count 3 with a simultaneous push
      push_word(32'h1111_0001);
      push_word(32'h1111_0002);
      push_word(32'h1111_0003);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.instr_in = 32'hDEAD_BEEF;
      #1;
      check_eq("flush_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check_eq("flush_count", 64'(bus.count), 64'd0);
      check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
      check_eq("flush_instr_out", 64'(bus.instr_out), 64'd0);
      push_word(32'h2222_0001);
      check_eq("post_flush_head", 64'(bus.instr_out), 64'h2222_0001);
      check_eq("post_flush_count", 64'(bus.count), 64'd1);
      pop_one();

      // Push into empty queue: same-cycle visibility only with the bypass
      bus.in_valid = 1'b1;
      bus.instr_in = 32'h0800_0040;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      check_eq("bypass_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bypass_target", 64'(bus.target26), 64'h40);
`else
      check_eq("nobypass_valid", 64'(bus.out_valid), 64'd0);
      check_eq("nobypass_target", 64'(bus.target26), 64'd0);
`endif
      tick();
      bus.in_valid = 1'b0;
      #1;
      check_eq("latency_count", 64'(bus.count), 64'd1);
      check_eq("latency_opcode", 64'(bus.opcode), 64'h02);
      pop_one();

      // Mid-stream reset with flush also asserted
      push_word(32'h3333_0001);
      push_word(32'h3333_0002);
      reset     = 1'b1;
      bus.flush = 1'b1;
      tick();
      reset     = 1'b0;
      bus.flush = 1'b0;
      #1;
      check_eq("midrst_count", 64'(bus.count), 64'd0);
      check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("midrst_funct", 64'(bus.funct), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
